// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, default widths and RAM byte stride for the FIR result path.
package fir_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 1024;
    localparam int BYTE_STRIDE = 4;
endpackage

// File: rtl/fir_result_sink.sv
// fir_result_sink: captures the FIR output stream into a bram32 result RAM,
// counting beats, summing data and flagging TLAST placement and overflow errors.
module fir_result_sink
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = ADDR_W,
    parameter int pDATA_WIDTH = DATA_W,
    parameter int pDEPTH      = DEPTH
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic [31:0]            cfg_len,
    input  logic                   cfg_start,
    input  logic                   sink_hold,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [3:0]             ram_WE,
    output logic                   ram_EN,
    output logic [pDATA_WIDTH-1:0] ram_Di,
    output logic [pADDR_WIDTH-1:0] ram_A,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            beat_cnt,
    output logic [pDATA_WIDTH-1:0] checksum,
    output logic                   err_early_last,
    output logic                   err_no_last,
    output logic                   err_overflow
);
    state_t                 state_q, state_d;
    logic [31:0]            len_q, len_d, cnt_q, cnt_d, n, addr_full;
    logic [pDATA_WIDTH-1:0] sum_q, sum_d;
    logic                   early_q, early_d, nolast_q, nolast_d, ovf_q, ovf_d;
    logic                   acc, in_range;

    assign s_tready  = (state_q == RUN) & ~sink_hold;
    assign acc       = s_tvalid & s_tready;
    assign in_range  = cnt_q < 32'(pDEPTH);
    assign n         = cnt_q + 32'd1;
    assign addr_full = cnt_q * 32'(BYTE_STRIDE);
    // Beats past the RAM capacity still count and sum, but never reach the RAM port.
    assign ram_EN    = acc & in_range;
    assign ram_WE    = {4{ram_EN}};
    assign ram_Di    = ram_EN ? s_tdata : '0;
    assign ram_A     = ram_EN ? addr_full[pADDR_WIDTH-1:0] : '0;

    assign busy           = state_q == RUN;
    assign done           = state_q == DONE;
    assign beat_cnt       = cnt_q;
    assign checksum       = sum_q;
    assign err_early_last = early_q;
    assign err_no_last    = nolast_q;
    assign err_overflow   = ovf_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        early_d  = early_q;
        nolast_d = nolast_q;
        ovf_d    = ovf_q;
        if (cfg_start && state_q != RUN) begin
            len_d    = cfg_len;
            cnt_d    = '0;
            sum_d    = '0;
            early_d  = 1'b0;
            nolast_d = 1'b0;
            ovf_d    = 1'b0;
            state_d  = (cfg_len != 32'd0) ? RUN : DONE;
        end else if (acc) begin
            cnt_d    = n;
            sum_d    = sum_q + s_tdata;
            ovf_d    = ovf_q | ~in_range;
            early_d  = early_q | (s_tlast & (n < len_q));
            nolast_d = nolast_q | ((n == len_q) & ~s_tlast);
            state_d  = (s_tlast || n == len_q) ? DONE : RUN;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            early_q  <= 1'b0;
            nolast_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            early_q  <= early_d;
            nolast_q <= nolast_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_fir_result_sink.sv
// tb_fir_result_sink: table vectors, hand sequences and random runs checked
// against a beat-list model; a 4-word instance shares stimulus to exercise overflow.
module tb_fir_result_sink;
    logic        axis_clk = 1'b0, axis_rst = 1'b1;
    logic [31:0] cfg_len = '0;
    logic        cfg_start = 1'b0, sink_hold = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;

    logic        m_rdy, m_en, m_busy, m_done, m_early, m_nolast, m_ovf;
    logic [3:0]  m_we;
    logic [31:0] m_di, m_cnt, m_sum;
    logic [11:0] m_a;
    logic        k_rdy, k_en, k_busy, k_done, k_early, k_nolast, k_ovf;
    logic [3:0]  k_we;
    logic [31:0] k_di, k_cnt, k_sum;
    logic [11:0] k_a;

    int total = 0, bad = 0, we_bad = 0;
    logic [31:0] wa_m[$], wd_m[$], wa_k[$], wd_k[$];
    logic [31:0] stim_d[$];
    bit          stim_l[$];
    bit          tog = 1'b0;

    always #5 axis_clk = ~axis_clk;

    fir_result_sink u_dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .cfg_len(cfg_len), .cfg_start(cfg_start),
        .sink_hold(sink_hold), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(m_rdy), .ram_WE(m_we), .ram_EN(m_en), .ram_Di(m_di), .ram_A(m_a),
        .busy(m_busy), .done(m_done), .beat_cnt(m_cnt), .checksum(m_sum),
        .err_early_last(m_early), .err_no_last(m_nolast), .err_overflow(m_ovf)
    );

    fir_result_sink #(.pDEPTH(4)) u_small (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .cfg_len(cfg_len), .cfg_start(cfg_start),
        .sink_hold(sink_hold), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(k_rdy), .ram_WE(k_we), .ram_EN(k_en), .ram_Di(k_di), .ram_A(k_a),
        .busy(k_busy), .done(k_done), .beat_cnt(k_cnt), .checksum(k_sum),
        .err_early_last(k_early), .err_no_last(k_nolast), .err_overflow(k_ovf)
    );

    always @(negedge axis_clk) begin
        if (m_en) begin wa_m.push_back(32'(m_a)); wd_m.push_back(m_di); end
        if (k_en) begin wa_k.push_back(32'(k_a)); wd_k.push_back(k_di); end
        if ((m_en ? 4'hF : 4'h0) != m_we || (k_en ? 4'hF : 4'h0) != k_we) we_bad++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start(input int len);
        cfg_len = 32'(len); cfg_start = 1'b1;
        @(posedge axis_clk); #1;
        cfg_start = 1'b0;
        wa_m.delete(); wd_m.delete(); wa_k.delete(); wd_k.delete();
        #1;
        chk("busy_after_start", 32'(m_busy), 32'(len != 0));
        chk("done_after_start", 32'(m_done), 32'(len == 0));
    endtask

    // mode 0: always ready, 1: hold toggles each cycle, 2: random hold and valid gaps
    task automatic send_beat(input logic [31:0] d, input bit l, input int mode);
        bit acc = 1'b0;
        if (mode == 2) repeat ($urandom_range(0, 2)) begin s_tvalid = 1'b0; @(posedge axis_clk); #1; end
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        for (int t = 0; t < 200 && !acc; t++) begin
            sink_hold = (mode == 1) ? tog : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            tog = ~tog;
            #1 acc = m_rdy;
            @(posedge axis_clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; sink_hold = 1'b0;
        if (!acc) begin total++; bad++; $display("FAIL beat_timeout: got not_accepted expected accepted"); end
    endtask

    task automatic drive(input int len, input int mode);
        start(len);
        for (int i = 0; i < len; i++) begin
            send_beat(stim_d[i], stim_l[i], mode);
            if (stim_l[i] || i + 1 == len) break;
        end
    endtask

    task automatic finish_check(input int cnt, input logic [31:0] sum, input bit early,
                                input bit nolast, input bit ovf_k);
        #1;
        chk("tready_after_done", 32'(m_rdy), 32'd0);
        s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF; s_tlast = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1 s_tvalid = 1'b0;
        chk("done", 32'(m_done), 32'd1);
        chk("busy", 32'(m_busy), 32'd0);
        chk("beat_cnt", m_cnt, 32'(cnt));
        chk("checksum", m_sum, sum);
        chk("err_early_last", 32'(m_early), 32'(early));
        chk("err_no_last", 32'(m_nolast), 32'(nolast));
        chk("err_overflow_main", 32'(m_ovf), 32'd0);
        chk("err_overflow_small", 32'(k_ovf), 32'(ovf_k));
        chk("small_beat_cnt", k_cnt, 32'(cnt));
        chk("small_checksum", k_sum, sum);
        chk("writes_main", 32'(wa_m.size()), 32'(cnt));
        chk("writes_small", 32'(wa_k.size()), 32'(cnt > 4 ? 4 : cnt));
        chk("we_consistency", 32'(we_bad), 32'd0);
        for (int i = 0; i < wa_m.size() && i < cnt; i++) begin
            chk($sformatf("ram_a[%0d]", i), wa_m[i], 32'(i * 4));
            chk($sformatf("ram_di[%0d]", i), wd_m[i], stim_d[i]);
        end
        for (int i = 0; i < wa_k.size() && i < 4; i++) chk($sformatf("small_di[%0d]", i), wd_k[i], stim_d[i]);
    endtask

    task automatic fill_index(input int len, input int lastp);
        stim_d.delete(); stim_l.delete();
        for (int i = 1; i <= len; i++) begin stim_d.push_back(32'(i)); stim_l.push_back(i == lastp); end
    endtask

    typedef struct {
        int len; int lastp; int mode;
        int cnt; int sum; bit early; bit nolast; bit ovf_k;
    } vec_t;

    initial begin
        vec_t vt[9];
        vt[0] = '{4, 4, 0, 4, 10, 0, 0, 0};
        vt[1] = '{8, 5, 0, 5, 15, 1, 0, 1};
        vt[2] = '{3, 0, 0, 3, 6, 0, 1, 0};
        vt[3] = '{6, 6, 1, 6, 21, 0, 0, 1};
        vt[4] = '{6, 6, 2, 6, 21, 0, 0, 1};
        vt[5] = '{1, 1, 0, 1, 1, 0, 0, 0};
        vt[6] = '{2, 1, 0, 1, 1, 1, 0, 0};
        vt[7] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[8] = '{5, 0, 2, 5, 15, 0, 1, 1};

        repeat (3) @(posedge axis_clk);
        #1 axis_rst = 1'b0;
        #1;
        chk("rst_tready", 32'(m_rdy), 32'd0);
        chk("rst_status", {m_busy, m_done, m_early, m_nolast, m_ovf, m_en, m_we}, 32'd0);
        chk("rst_cnt_sum", m_cnt | m_sum, 32'd0);

        foreach (vt[v]) begin
            fill_index(vt[v].len, vt[v].lastp);
            drive(vt[v].len, vt[v].mode);
            finish_check(vt[v].cnt, 32'(vt[v].sum), vt[v].early, vt[v].nolast, vt[v].ovf_k);
        end

        // cfg_start while running must not restart the capture
        fill_index(4, 4);
        start(4);
        send_beat(1, 0, 0);
        cfg_len = 32'd2; cfg_start = 1'b1;
        @(posedge axis_clk); #1 cfg_start = 1'b0;
        for (int i = 1; i < 4; i++) send_beat(stim_d[i], stim_l[i], 0);
        finish_check(4, 10, 0, 0, 0);

        // reset in the middle of a capture, then a clean capture from address 0
        fill_index(5, 5);
        start(5);
        send_beat(1, 0, 0);
        send_beat(2, 0, 0);
        axis_rst = 1'b1;
        @(posedge axis_clk); #1;
        s_tvalid = 1'b1; s_tdata = 32'h55;
        #1;
        chk("midrst_tready", 32'(m_rdy), 32'd0);
        chk("midrst_status", {m_busy, m_done, m_early, m_nolast, m_ovf, m_en, m_we}, 32'd0);
        chk("midrst_cnt_sum", m_cnt | m_sum, 32'd0);
        @(posedge axis_clk); #1 axis_rst = 1'b0;
        @(posedge axis_clk); #1 s_tvalid = 1'b0;
        chk("midrst_no_writes", 32'(wa_m.size()), 32'd2);
        fill_index(3, 3);
        drive(3, 0);
        finish_check(3, 6, 0, 0, 0);

        for (int r = 0; r < 25; r++) begin
            int len, lastp, k;
            logic [31:0] sum;
            len = $urandom_range(1, 12);
            lastp = $urandom_range(0, len + 2);
            stim_d.delete(); stim_l.delete();
            for (int i = 1; i <= len; i++) begin stim_d.push_back($urandom); stim_l.push_back(i == lastp); end
            k = len;
            for (int i = 0; i < len; i++) if (stim_l[i]) begin k = i + 1; break; end
            sum = '0;
            for (int i = 0; i < k; i++) sum += stim_d[i];
            drive(len, r % 3);
            finish_check(k, sum, stim_l[k-1] && k < len, !stim_l[k-1] && k == len, k > 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
